cpu_trace_buffer: RTL and testbench

Synthesizable on-chip successor to per-cycle register/PC text dumping. It captures retired-instruction records (pc, instr, register writeback) into a parametrised circular buffer. Capture is PC-match triggered, with a programmable post-trigger count and selectable wrap or stop-when-full mode. It sits beside the cpu top level, fed from the writeback stage, and is read out through a valid/ready port for PS/2 or 7-seg debug paths and for simulation benches.

---
 rtl/cpu_trace_pkg.sv | 40 ++++
 rtl/trace_ram.sv | 33 +++
 rtl/cpu_trace_buffer.sv | 191 +++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// ============================================================================
// Module : cpu_trace_pkg
// Brief  : Shared state encoding and record layout for the CPU trace buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Record layout, LSB first: pc | instr | wb_data | wb_addr | wb_en
  function automatic int rec_width(input int pc_w, input int data_w, input int reg_aw);
    return pc_w + 2 * data_w + 1 + reg_aw;
  endfunction

  function automatic int off_instr(input int pc_w);
    return pc_w;
  endfunction

  function automatic int off_wb_data(input int pc_w, input int data_w);
    return pc_w + data_w;
  endfunction

  function automatic int off_wb_addr(input int pc_w, input int data_w);
    return pc_w + 2 * data_w;
  endfunction

  function automatic int off_wb_en(input int pc_w, input int data_w, input int reg_aw);
    return pc_w + 2 * data_w + reg_aw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================================
// Module : trace_ram
// Brief  : DEPTH x WIDTH record store, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 102,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
// ============================================================================
// Module : cpu_trace_buffer
// Brief  : PC-triggered circular capture of retired-instruction records.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk100mhz,
  input  logic              frst,
  input  logic              cap_valid,
  input  logic [PC_W-1:0]   cap_pc,
  input  logic [DATA_W-1:0] cap_instr,
  input  logic              cap_wb_en,
  input  logic [REG_AW-1:0] cap_wb_addr,
  input  logic [DATA_W-1:0] cap_wb_data,
  input  logic              arm,
  input  logic              mode_wrap,
  input  logic              trig_en,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic [ADDR_W:0]   post_count,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [PC_W-1:0]   rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic              rd_wb_en,
  output logic [REG_AW-1:0] rd_wb_addr,
  output logic [DATA_W-1:0] rd_wb_data,
  output logic [ADDR_W:0]   level,
  output logic              triggered,
  output logic              done,
  output logic              overflow
);

  localparam int REG_REC_W   = rec_width(PC_W, DATA_W, REG_AW);
  localparam int REC_W       = REG_REC_W;
  localparam int c_off_instr = off_instr(PC_W);
  localparam int c_off_wbd   = off_wb_data(PC_W, DATA_W);
  localparam int c_off_wba   = off_wb_addr(PC_W, DATA_W);
  localparam int c_off_wbe   = off_wb_en(PC_W, DATA_W, REG_AW);
  localparam int LVL_W       = ADDR_W + 1;
  localparam logic [LVL_W-1:0] c_full     = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] c_full_m1  = LVL_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LVL_W-1:0]    post_cnt_q, post_cnt_d;
  logic                triggered_q, triggered_d;
  logic                overflow_q, overflow_d;

  logic                w_we;
  logic                w_hit;
  logic                w_full;
  logic                w_fills;
  logic                w_pop;
  logic [REC_W-1:0]    w_wr_rec;
  logic [REC_W-1:0]    w_rd_rec;

  assign w_hit    = trig_en && (cap_pc == trig_pc);
  assign w_full   = (level_q == c_full);
  assign w_fills  = (level_q == c_full_m1);
  assign rd_valid = (state_q == ST_DONE) && (level_q != '0);
  assign w_pop    = rd_valid && rd_ready;
  assign w_wr_rec = {cap_wb_en, cap_wb_addr, cap_wb_data, cap_instr, cap_pc};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    w_we        = 1'b0;

    if (arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          if (cap_valid) begin
            // Only reachable if mode_wrap drops while already full: freeze as-is.
            if (w_full && !mode_wrap) begin
              state_d = ST_DONE;
            end else begin
              w_we     = 1'b1;
              wr_ptr_d = wr_ptr_q + ADDR_W'(1);
              if (w_full) begin
                rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                overflow_d = 1'b1;
              end else begin
                level_d = level_q + LVL_W'(1);
              end

              if (state_q == ST_ARMED) begin
                if (w_hit) begin
                  triggered_d = 1'b1;
                  if (post_count == '0) begin
                    state_d = ST_DONE;
                  end else begin
                    post_cnt_d = post_count;
                    state_d    = ST_POST;
                  end
                end
              end else begin
                post_cnt_d = post_cnt_q - LVL_W'(1);
                if (post_cnt_q == LVL_W'(1)) begin
                  state_d = ST_DONE;
                end
              end

              if (!mode_wrap && w_fills) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (w_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            level_d  = level_q - LVL_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk100mhz or negedge frst) begin
    if (!frst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk     (clk100mhz),
    .i_we    (w_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (w_wr_rec),
    .i_raddr (rd_ptr_q),
    .o_rdata (w_rd_rec)
  );

  assign rd_pc      = w_rd_rec[PC_W-1:0];
  assign rd_instr   = w_rd_rec[c_off_instr +: DATA_W];
  assign rd_wb_data = w_rd_rec[c_off_wbd +: DATA_W];
  assign rd_wb_addr = w_rd_rec[c_off_wba +: REG_AW];
  assign rd_wb_en   = w_rd_rec[c_off_wbe];

  assign level     = level_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;
  assign done      = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
// ============================================================================
// Module : tb_cpu_trace_buffer
// Brief  : Table-driven capture scenarios with a readout scoreboard, DEPTH=8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_trace_buffer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_DONE = 3;

  logic        clk100mhz = 1'b0;
  logic        frst;
  logic        cap_valid, cap_wb_en, arm, mode_wrap, trig_en, rd_ready;
  logic [31:0] cap_pc, cap_instr, cap_wb_data, trig_pc;
  logic [4:0]  cap_wb_addr;
  logic [ADDR_W:0] post_count;
  logic        rd_valid, rd_wb_en, triggered, done, overflow;
  logic [31:0] rd_pc, rd_instr, rd_wb_data;
  logic [4:0]  rd_wb_addr;
  logic [ADDR_W:0] level;

  cpu_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32), .REG_AW(5)) dut (
    .clk100mhz (clk100mhz), .frst (frst),
    .cap_valid (cap_valid), .cap_pc (cap_pc), .cap_instr (cap_instr),
    .cap_wb_en (cap_wb_en), .cap_wb_addr (cap_wb_addr), .cap_wb_data (cap_wb_data),
    .arm (arm), .mode_wrap (mode_wrap), .trig_en (trig_en), .trig_pc (trig_pc),
    .post_count (post_count), .rd_ready (rd_ready),
    .rd_valid (rd_valid), .rd_pc (rd_pc), .rd_instr (rd_instr), .rd_wb_en (rd_wb_en),
    .rd_wb_addr (rd_wb_addr), .rd_wb_data (rd_wb_data),
    .level (level), .triggered (triggered), .done (done), .overflow (overflow)
  );

  always #5 clk100mhz = ~clk100mhz;

  int n_vec  = 0;
  int n_fail = 0;

  typedef logic [101:0] rec_t;
  rec_t q_exp[$];
  int   m_state;
  int   m_post;

  typedef struct {
    logic        wrap;
    logic        ten;
    logic [31:0] tpc;
    logic [3:0]  post;
    int          n;
    logic [3:0]  exp_level;
    logic        exp_trig;
    logic        exp_ovf;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk_rec(input logic [31:0] pc);
    logic [31:0] instr, wbd;
    instr = pc * 3 + 32'h13;
    wbd   = pc ^ 32'hDEAD_BEEF;
    return {pc[3], pc[6:2], wbd, instr, pc};
  endfunction

  // Abstract model of what the buffer should hold, independent of pointers.
  task automatic model_step(input logic [31:0] pc);
    if (m_state == M_ARMED || m_state == M_POST) begin
      if (q_exp.size() == DEPTH && !mode_wrap) begin
        m_state = M_DONE;
      end else begin
        if (q_exp.size() == DEPTH) void'(q_exp.pop_front());
        q_exp.push_back(mk_rec(pc));
        if (m_state == M_ARMED) begin
          if (trig_en && pc == trig_pc) begin
            if (post_count == 0) m_state = M_DONE;
            else begin m_post = int'(post_count); m_state = M_POST; end
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = M_DONE;
        end
        if (!mode_wrap && q_exp.size() == DEPTH) m_state = M_DONE;
      end
    end
  endtask

  task automatic drive_rec(input logic [31:0] pc);
    rec_t r;
    @(negedge clk100mhz);
    r = mk_rec(pc);
    cap_valid   = 1'b1;
    cap_pc      = pc;
    cap_instr   = r[63:32];
    cap_wb_data = r[95:64];
    cap_wb_addr = r[100:96];
    cap_wb_en   = r[101];
    model_step(pc);
  endtask

  task automatic do_arm();
    @(negedge clk100mhz);
    cap_valid = 1'b0;
    arm       = 1'b1;
    @(negedge clk100mhz);
    arm = 1'b0;
    q_exp.delete();
    m_state = M_ARMED;
    m_post  = 0;
  endtask

  task automatic readout(input bit backpressure, output logic [31:0] first_pc,
                         output logic [31:0] last_pc);
    int   k;
    bit   seen;
    rec_t act;
    k = 0;
    seen = 0;
    first_pc = '0;
    last_pc  = '0;
    while (1) begin
      @(negedge clk100mhz);
      chk("rd_valid", 128'(rd_valid), 128'(q_exp.size() != 0));
      act = {rd_wb_en, rd_wb_addr, rd_wb_data, rd_instr, rd_pc};
      if (rd_valid && q_exp.size() != 0) begin
        chk("rd_record", 128'(act), 128'(q_exp[0]));
        if (!seen) begin first_pc = rd_pc; seen = 1; end
      end
      rd_ready = backpressure ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (rd_valid && rd_ready && q_exp.size() != 0) begin
        last_pc = rd_pc;
        void'(q_exp.pop_front());
      end
      if (!rd_valid && q_exp.size() == 0) break;
      k++;
      if (k > 200) begin
        chk("readout_budget", 128'(k), 128'(0));
        break;
      end
    end
    rd_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] fpc, lpc;

    vecs[0] = '{1'b0, 1'b0, 32'h00, 4'd0, 10, 4'd8, 1'b0, 1'b0, 32'h00, 32'h1c};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 4'd3, 30, 4'd8, 1'b1, 1'b1, 32'h30, 32'h4c};
    vecs[2] = '{1'b0, 1'b1, 32'h10, 4'd0, 10, 4'd5, 1'b1, 1'b0, 32'h00, 32'h10};
    vecs[3] = '{1'b1, 1'b1, 32'h08, 4'd2, 10, 4'd5, 1'b1, 1'b0, 32'h00, 32'h10};
    vecs[4] = '{1'b0, 1'b1, 32'h14, 4'd5, 10, 4'd8, 1'b1, 1'b0, 32'h00, 32'h1c};
    vecs[5] = '{1'b0, 1'b1, 32'h1c, 4'd3, 10, 4'd8, 1'b1, 1'b0, 32'h00, 32'h1c};
    vecs[6] = '{1'b1, 1'b1, 32'h04, 4'd9, 20, 4'd8, 1'b1, 1'b1, 32'h0c, 32'h28};

    frst = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_wb_en = 1'b0;
    cap_wb_addr = '0; cap_wb_data = '0; arm = 1'b0; mode_wrap = 1'b0; trig_en = 1'b0;
    trig_pc = '0; post_count = '0; rd_ready = 1'b0;
    m_state = M_IDLE; m_post = 0;
    repeat (3) @(negedge clk100mhz);
    frst = 1'b1;
    @(negedge clk100mhz);
    chk("reset_level", 128'(level), 128'(0));
    chk("reset_flags", 128'({rd_valid, triggered, done, overflow}), 128'(0));

    // Capture is ignored before the first arm.
    drive_rec(32'h0);
    @(negedge clk100mhz);
    cap_valid = 1'b0;
    chk("idle_ignore_level", 128'(level), 128'(0));

    for (int v = 0; v < 7; v++) begin
      mode_wrap  = vecs[v].wrap;
      trig_en    = vecs[v].ten;
      trig_pc    = vecs[v].tpc;
      post_count = vecs[v].post;
      do_arm();
      for (int i = 0; i < vecs[v].n; i++) drive_rec(32'(i * 4));
      @(negedge clk100mhz);
      cap_valid = 1'b0;
      chk($sformatf("v%0d_level", v), 128'(level), 128'(vecs[v].exp_level));
      chk($sformatf("v%0d_triggered", v), 128'(triggered), 128'(vecs[v].exp_trig));
      chk($sformatf("v%0d_overflow", v), 128'(overflow), 128'(vecs[v].exp_ovf));
      chk($sformatf("v%0d_done", v), 128'(done), 128'(1));
      readout(v % 2 == 1, fpc, lpc);
      chk($sformatf("v%0d_first_pc", v), 128'(fpc), 128'(vecs[v].exp_first));
      chk($sformatf("v%0d_last_pc", v), 128'(lpc), 128'(vecs[v].exp_last));
      chk($sformatf("v%0d_empty_level", v), 128'(level), 128'(0));
    end

    // Re-arm from DONE with level 5 while a matching record is presented.
    mode_wrap = 1'b0; trig_en = 1'b1; trig_pc = 32'h10; post_count = 4'd0;
    do_arm();
    for (int i = 0; i < 10; i++) drive_rec(32'(i * 4));
    @(negedge clk100mhz);
    cap_valid = 1'b0;
    chk("rearm_pre_level", 128'(level), 128'(5));
    chk("rearm_pre_done", 128'(done), 128'(1));
    arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h10;
    @(negedge clk100mhz);
    arm = 1'b0; cap_valid = 1'b0;
    chk("rearm_level", 128'(level), 128'(0));
    chk("rearm_flags", 128'({done, triggered, overflow, rd_valid}), 128'(0));
    trig_en = 1'b0;
    drive_rec(32'h200);
    @(negedge clk100mhz);
    cap_valid = 1'b0;
    chk("rearm_armed_level", 128'(level), 128'(1));
    chk("rearm_armed_done", 128'(done), 128'(0));

    // Asynchronous reset in the middle of POST.
    mode_wrap = 1'b0; trig_en = 1'b1; trig_pc = 32'h0; post_count = 4'd10;
    do_arm();
    for (int i = 0; i < 6; i++) drive_rec(32'(i * 4));
    @(negedge clk100mhz);
    cap_valid = 1'b0;
    chk("post_level", 128'(level), 128'(6));
    chk("post_trig_notdone", 128'({triggered, done}), 128'(2'b10));
    #2 frst = 1'b0;
    #1;
    chk("async_rst_level", 128'(level), 128'(0));
    chk("async_rst_flags", 128'({rd_valid, triggered, done, overflow}), 128'(0));
    @(negedge clk100mhz);
    frst = 1'b1;
    m_state = M_IDLE;
    for (int i = 0; i < 3; i++) drive_rec(32'(i * 4));
    @(negedge clk100mhz);
    cap_valid = 1'b0;
    chk("post_rst_ignore_level", 128'(level), 128'(0));
    chk("post_rst_ignore_done", 128'(done), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
